// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing one dual-read/single-write register file between two requesters,
// with an optional post-reset zero sweep of every register before requests are accepted.
module rf_access_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_src1,
    input  logic [ADDR_W-1:0] req0_src2,
    input  logic [ADDR_W-1:0] req0_dest,
    input  logic              req0_we,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_src1,
    input  logic [ADDR_W-1:0] req1_src2,
    input  logic [ADDR_W-1:0] req1_dest,
    input  logic              req1_we,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data1,
    output logic [DATA_W-1:0] rsp0_data2,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data1,
    output logic [DATA_W-1:0] rsp1_data2,

    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_src1_addr,
    output logic [ADDR_W-1:0] rf_src2_addr,
    output logic [ADDR_W-1:0] rf_dest_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,

    output logic              init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam state_t            RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_REGS - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] init_cnt_reg;
    logic              ptr_reg;

    logic              init_phase;
    logic              run_phase;
    logic [1:0]        grant;

    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_src1  [2];
    logic [ADDR_W-1:0] req_src2  [2];
    logic [ADDR_W-1:0] req_dest  [2];
    logic [DATA_W-1:0] req_wdata [2];

    logic [ADDR_W-1:0] sel_src1  [2];
    logic [ADDR_W-1:0] sel_src2  [2];
    logic [ADDR_W-1:0] sel_dest  [2];
    logic [DATA_W-1:0] sel_wdata [2];

    logic [1:0]        rsp_valid_vec;
    logic [DATA_W-1:0] rsp_data1_arr [2];
    logic [DATA_W-1:0] rsp_data2_arr [2];

    assign req_valid    = {req1_valid, req0_valid};
    assign req_we       = {req1_we, req0_we};
    assign req_src1[0]  = req0_src1;
    assign req_src1[1]  = req1_src1;
    assign req_src2[0]  = req0_src2;
    assign req_src2[1]  = req1_src2;
    assign req_dest[0]  = req0_dest;
    assign req_dest[1]  = req1_dest;
    assign req_wdata[0] = req0_wdata;
    assign req_wdata[1] = req1_wdata;

    // Gating with rst keeps every output low while reset is held, even in the reset state.
    assign init_phase = rst && (state_reg == ST_INIT);
    assign run_phase  = rst && (state_reg == ST_RUN);

    always_comb begin
        grant = 2'b00;
        if (run_phase) begin
            if (req_valid[0] && (!req_valid[1] || !ptr_reg)) begin
                grant[0] = 1'b1;
            end else if (req_valid[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    // Grant is one-hot or zero, so masking each request and OR-ing forms the port mux.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic              rsp_valid_reg;
            logic [DATA_W-1:0] rsp_data1_reg;
            logic [DATA_W-1:0] rsp_data2_reg;

            assign sel_src1[gi]  = grant[gi] ? req_src1[gi]  : '0;
            assign sel_src2[gi]  = grant[gi] ? req_src2[gi]  : '0;
            assign sel_dest[gi]  = grant[gi] ? req_dest[gi]  : '0;
            assign sel_wdata[gi] = grant[gi] ? req_wdata[gi] : '0;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rsp_valid_reg <= 1'b0;
                    rsp_data1_reg <= '0;
                    rsp_data2_reg <= '0;
                end else begin
                    rsp_valid_reg <= grant[gi];
                    if (grant[gi]) begin
                        rsp_data1_reg <= rf_read_data1;
                        rsp_data2_reg <= rf_read_data2;
                    end
                end
            end

            assign rsp_valid_vec[gi] = rsp_valid_reg;
            assign rsp_data1_arr[gi] = rsp_data1_reg;
            assign rsp_data2_arr[gi] = rsp_data2_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RESET_STATE;
            init_cnt_reg <= '0;
            ptr_reg      <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            init_cnt_reg <= init_cnt_reg + 1'b1;
            if (init_cnt_reg == LAST_ADDR) begin
                state_reg <= ST_RUN;
            end
        end else begin
            if (grant[0]) begin
                ptr_reg <= 1'b1;
            end else if (grant[1]) begin
                ptr_reg <= 1'b0;
            end
        end
    end

    assign req0_ready    = grant[0];
    assign req1_ready    = grant[1];
    assign init_done     = run_phase;

    assign rf_wr_en      = init_phase | (|(grant & req_we));
    assign rf_src1_addr  = sel_src1[0] | sel_src1[1];
    assign rf_src2_addr  = sel_src2[0] | sel_src2[1];
    assign rf_dest_addr  = init_phase ? init_cnt_reg : (sel_dest[0] | sel_dest[1]);
    assign rf_write_data = sel_wdata[0] | sel_wdata[1];

    assign rsp0_valid    = rsp_valid_vec[0];
    assign rsp1_valid    = rsp_valid_vec[1];
    assign rsp0_data1    = rsp_data1_arr[0];
    assign rsp0_data2    = rsp_data2_arr[0];
    assign rsp1_data1    = rsp_data1_arr[1];
    assign rsp1_data2    = rsp_data2_arr[1];

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural register file behind it.
module tb_rf_access_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_src1 = 0, req0_src2 = 0, req0_dest = 0;
    logic [4:0]  req1_src1 = 0, req1_src2 = 0, req1_dest = 0;
    logic        req0_we = 0, req1_we = 0;
    logic [31:0] req0_wdata = 0, req1_wdata = 0;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data1, rsp0_data2, rsp1_data1, rsp1_data2;
    logic        rf_wr_en;
    logic [4:0]  rf_src1_addr, rf_src2_addr, rf_dest_addr;
    logic [31:0] rf_write_data, rf_read_data1, rf_read_data2;
    logic        init_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] regs [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_wr_en) regs[rf_dest_addr] <= rf_write_data;
    end
    assign rf_read_data1 = regs[rf_src1_addr];
    assign rf_read_data2 = regs[rf_src2_addr];

    rf_access_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_dest(req0_dest), .req0_we(req0_we), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_dest(req1_dest), .req1_we(req1_we), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_data1(rsp0_data1), .rsp0_data2(rsp0_data2),
        .rsp1_valid(rsp1_valid), .rsp1_data1(rsp1_data1), .rsp1_data2(rsp1_data2),
        .rf_wr_en(rf_wr_en), .rf_src1_addr(rf_src1_addr), .rf_src2_addr(rf_src2_addr),
        .rf_dest_addr(rf_dest_addr), .rf_write_data(rf_write_data),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .init_done(init_done)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_wr_en, init_done} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctl got=%b exp=000000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rf_wr_en, init_done});
        end
        n_cmp++;
        if ({rf_src1_addr, rf_src2_addr, rf_dest_addr, rf_write_data, rsp0_data1, rsp1_data2} !== '0) begin
            n_bad++; $display("FAIL reset_data got=%0h exp=0", {rf_src1_addr, rf_src2_addr, rf_dest_addr, rf_write_data, rsp0_data1, rsp1_data2});
        end
        n_cmp++;
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if ({rf_wr_en, rf_dest_addr, rf_write_data} !== {1'b1, 5'(c), 32'h0}) begin
                n_bad++; $display("FAIL init_write c=%0d got we=%b dest=%0d data=%0h exp we=1 dest=%0d data=0", c, rf_wr_en, rf_dest_addr, rf_write_data, c);
            end
            n_cmp++;
            if ({req0_ready, init_done} !== 2'b00) begin
                n_bad++; $display("FAIL init_ready c=%0d got ready=%b done=%b exp 0 0", c, req0_ready, init_done);
            end
            n_cmp++;
            next_cycle();
        end
        @(negedge clk);
        if ({init_done, req0_ready} !== 2'b11) begin
            n_bad++; $display("FAIL run_entry got done=%b ready=%b exp 1 1", init_done, req0_ready);
        end
        n_cmp++;
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        if ({rsp0_valid, rsp0_data1} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL swept_reg0 got v=%b d=%0h exp v=1 d=0", rsp0_valid, rsp0_data1);
        end
        n_cmp++;
        next_cycle();
    endtask

    task automatic test_write_read();
        req0_valid = 1'b1; req0_we = 1'b1; req0_dest = 5'd4; req0_wdata = 32'd10;
        req0_src1 = 5'd0; req0_src2 = 5'd0;
        @(negedge clk);
        if ({req0_ready, rf_wr_en, rf_dest_addr, rf_write_data} !== {1'b1, 1'b1, 5'd4, 32'd10}) begin
            n_bad++; $display("FAIL wr_ports got rdy=%b we=%b dest=%0d data=%0h exp 1 1 4 a", req0_ready, rf_wr_en, rf_dest_addr, rf_write_data);
        end
        n_cmp++;
        next_cycle();
        req0_we = 1'b0; req0_src1 = 5'd4; req0_src2 = 5'd3;
        @(negedge clk);
        if ({rf_wr_en, rf_src1_addr, rf_src2_addr, rf_dest_addr, rf_write_data} !== {1'b0, 5'd4, 5'd3, 5'd4, 32'd10}) begin
            n_bad++; $display("FAIL rd_ports got we=%b s1=%0d s2=%0d exp we=0 s1=4 s2=3", rf_wr_en, rf_src1_addr, rf_src2_addr);
        end
        n_cmp++;
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        if ({rsp0_valid, rsp0_data1, rsp0_data2} !== {1'b1, 32'd10, 32'd0}) begin
            n_bad++; $display("FAIL wr_then_rd got v=%b d1=%0h d2=%0h exp v=1 d1=a d2=0", rsp0_valid, rsp0_data1, rsp0_data2);
        end
        n_cmp++;
        next_cycle();
        @(negedge clk);
        if (rsp0_valid !== 1'b0) begin
            n_bad++; $display("FAIL rsp_pulse got=%b exp=0", rsp0_valid);
        end
        n_cmp++;
        next_cycle();
    endtask

    task automatic test_lone_req1();
        req1_valid = 1'b1; req1_we = 1'b0; req1_src1 = 5'd4; req1_src2 = 5'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if ({req1_ready, req0_ready} !== 2'b10) begin
                n_bad++; $display("FAIL lone_grant c=%0d got r1=%b r0=%b exp 1 0", c, req1_ready, req0_ready);
            end
            n_cmp++;
            if (c > 0 && rsp1_valid !== 1'b1) begin
                n_bad++; $display("FAIL lone_rsp c=%0d got=%b exp=1", c, rsp1_valid);
            end
            n_cmp++;
            next_cycle();
        end
        req1_valid = 1'b0;
        @(negedge clk);
        if ({rsp1_valid, rsp1_data1, rsp0_valid} !== {1'b1, 32'd10, 1'b0}) begin
            n_bad++; $display("FAIL lone_last got v1=%b d1=%0h v0=%b exp 1 a 0", rsp1_valid, rsp1_data1, rsp0_valid);
        end
        n_cmp++;
        next_cycle();
    endtask

    task automatic test_both_valid();
        logic exp_g;
        logic prev_g;
        req0_valid = 1'b1; req0_we = 1'b1; req0_dest = 5'd7; req0_wdata = 32'h77;
        req0_src1 = 5'd1; req0_src2 = 5'd0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_src1 = 5'd2; req1_src2 = 5'd4;
        prev_g = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp_g = c[0];
            @(negedge clk);
            if ({req0_ready, req1_ready} !== {~exp_g, exp_g}) begin
                n_bad++; $display("FAIL rr_grant c=%0d got r0=%b r1=%b exp %b %b", c, req0_ready, req1_ready, ~exp_g, exp_g);
            end
            n_cmp++;
            if ({rf_wr_en, rf_src1_addr} !== {~exp_g, (exp_g ? 5'd2 : 5'd1)}) begin
                n_bad++; $display("FAIL rr_ports c=%0d got we=%b s1=%0d exp we=%b s1=%0d", c, rf_wr_en, rf_src1_addr, ~exp_g, exp_g ? 2 : 1);
            end
            n_cmp++;
            if (c > 0 && {rsp0_valid, rsp1_valid} !== {~prev_g, prev_g}) begin
                n_bad++; $display("FAIL rr_rsp c=%0d got v0=%b v1=%b exp %b %b", c, rsp0_valid, rsp1_valid, ~prev_g, prev_g);
            end
            n_cmp++;
            prev_g = exp_g;
            next_cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; req0_we = 1'b0;
        @(negedge clk);
        if ({rsp0_valid, rsp1_valid} !== 2'b01) begin
            n_bad++; $display("FAIL rr_last got v0=%b v1=%b exp 0 1", rsp0_valid, rsp1_valid);
        end
        n_cmp++;
        next_cycle();
    endtask

    task automatic test_same_cycle_rw();
        req0_valid = 1'b1; req0_we = 1'b1; req0_dest = 5'd5; req0_src1 = 5'd5;
        req0_src2 = 5'd0; req0_wdata = 32'hAA;
        next_cycle();
        req0_we = 1'b0;
        @(negedge clk);
        if (rsp0_data1 !== 32'h0) begin
            n_bad++; $display("FAIL same_cycle_old got=%0h exp=0", rsp0_data1);
        end
        n_cmp++;
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        if (rsp0_data1 !== 32'hAA) begin
            n_bad++; $display("FAIL same_cycle_new got=%0h exp=aa", rsp0_data1);
        end
        n_cmp++;
        next_cycle();
    endtask

    task automatic test_reset_mid_run();
        req0_valid = 1'b1; req0_we = 1'b0; req0_src1 = 5'd4; req0_src2 = 5'd0;
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        if ({req0_ready, rsp0_valid, rsp0_data1, rf_wr_en, rf_src1_addr, init_done} !== '0) begin
            n_bad++; $display("FAIL async_clear got r=%b v=%b d=%0h we=%b s1=%0d done=%b exp all 0", req0_ready, rsp0_valid, rsp0_data1, rf_wr_en, rf_src1_addr, init_done);
        end
        n_cmp++;
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (c == 0 && {rf_wr_en, rf_dest_addr, rsp0_valid} !== {1'b1, 5'd0, 1'b0}) begin
                n_bad++; $display("FAIL reinit_start got we=%b dest=%0d v=%b exp 1 0 0", rf_wr_en, rf_dest_addr, rsp0_valid);
            end
            n_cmp++;
            next_cycle();
        end
        req1_valid = 1'b1; req1_we = 1'b0; req1_src1 = 5'd0; req1_src2 = 5'd0;
        @(negedge clk);
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL ptr_reset got r0=%b r1=%b exp 1 0", req0_ready, req1_ready);
        end
        n_cmp++;
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        if ({rsp0_valid, rsp0_data1} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL reg4_swept got v=%b d=%0h exp v=1 d=0", rsp0_valid, rsp0_data1);
        end
        n_cmp++;
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hDEAD_0000 + i;
        test_reset();
        test_write_read();
        test_lone_req1();
        test_both_valid();
        test_same_cycle_rw();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_access_arbiter.md
# rf_access_arbiter

Shares a single dual-read/single-write register file (`dp_reg_file`) between two requesters. Each cycle it grants at most one request, using round-robin priority. The granted request drives the register-file ports, and the read operands come back as a registered response. After reset it can sweep every register to zero before it accepts requests. It sits between the two issue sources and the register file.

## Interface
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.
- `NUM_REGS`, default 32: number of registers swept during init; must equal 2**ADDR_W.
- `INIT_ZERO`, default 1: 1 = zero-sweep after reset, 0 = go straight to RUN.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  grant; a transfer occurs when valid && ready.
- `reqN_src1`, `reqN_src2`  in  ADDR_W  read addresses.
- `reqN_dest`  in  ADDR_W  write address.
- `reqN_we`  in  1  request includes a write.
- `reqN_wdata`  in  DATA_W  write data.
- `rspN_valid`  out  1  one-cycle response pulse.
- `rspN_data1`, `rspN_data2`  out  DATA_W  registered read operands.
- `rf_wr_en`  out  1  register-file write enable.
- `rf_src1_addr`, `rf_src2_addr`, `rf_dest_addr`  out  ADDR_W  register-file addresses.
- `rf_write_data`  out  DATA_W  register-file write data.
- `rf_read_data1`, `rf_read_data2`  in  DATA_W  register-file read data, combinational.
- `init_done`  out  1  high once requests are accepted.

## Operation
- State machine with two states, INIT and RUN.
- Reset state is INIT when `INIT_ZERO`=1, otherwise RUN.

INIT:
- A counter runs 0..NUM_REGS-1.
- Each cycle: `rf_wr_en`=1, `rf_dest_addr`=counter, `rf_write_data`=0.
- Both ready outputs are 0; `init_done`=0.
- After the write to NUM_REGS-1, the block moves to RUN.

RUN:
- `init_done`=1.
- Priority pointer `ptr` resets to 0.
- Only one valid: that requester is granted.
- Both valid: requester `ptr` is granted.
- After any grant to r, `ptr` becomes !r. With no grant, `ptr` holds.
- A lone requester can be granted on consecutive cycles.
- The granted request drives the rf ports combinationally in the same cycle:
  - `rf_src1_addr` = src1, `rf_src2_addr` = src2, `rf_dest_addr` = dest.
  - `rf_write_data` = wdata, `rf_wr_en` = we.
- With no grant: `rf_wr_en`=0 and all rf address/data outputs are 0.
- At the edge ending the grant cycle:
  - `rf_read_data1/2` are captured into `rspN_data1/2` of the granted requester.
  - `rspN_valid` pulses for 1 cycle.
  - The other requester's rsp data holds its previous value.
- Responses cannot be backpressured; requesters must consume `rspN_valid` when it pulses.
- Read during a write to the same address returns the pre-write contents. The block does no forwarding.
- Reads and writes to address 0 are passed through unmodified.

Reset:
- All outputs are 0 at reset: ready, rsp valid/data, rf outputs, `init_done`.
- `rf_wr_en` goes high in the first INIT cycle after reset deasserts.
- Reset asserted mid-INIT or mid-RUN clears state immediately (asynchronously).
- On release, the INIT sweep restarts from 0 and `ptr`=0.
- A request in flight at reset gets no response.

## Timing
- Grant (`reqN_ready`) is combinational from the valid inputs, `ptr` and state. It never depends on `rf_read_data`.
- Accept in cycle N gives `rspN_valid` in cycle N+1.
- Throughput: one request per cycle, summed over both requesters.
- INIT takes exactly NUM_REGS cycles: cycles 0..NUM_REGS-1 after reset release.
  - `init_done` and ready are first possible in cycle NUM_REGS.
- The rf write takes effect at the edge ending the grant cycle.
  - A write granted in cycle N is visible to a read granted in cycle N+1.

## Test plan
- Reset release, `INIT_ZERO`=1, `req0_valid`=1 throughout:
  - `rf_wr_en`=1 for 32 cycles with `rf_dest_addr` 0..31 and data 0.
  - `req0_ready`=0 for those 32 cycles.
  - `init_done` and `req0_ready` rise in cycle 32.
- `req0` writes dest=4, wdata=10, we=1 in cycle N, then reads src1=4, src2=3 in cycle N+1:
  - `rsp0_valid` at N+2 with data1=10, data2=0.
- Both valid for 4 cycles:
  - Grants go 0,1,0,1.
  - rsp valids alternate one cycle later.
  - `rf_wr_en` follows each granted we.
- Only `req1` valid for 3 cycles:
  - `req1_ready`=1 on all 3 cycles.
  - 3 back-to-back `rsp1_valid` pulses.
  - Next both-valid cycle grants 0.
- Same-cycle write/read, dest=5 and src1=5, wdata=0xAA, reg5=0:
  - `rsp0_data1`=0.
  - Following read of 5 returns 0xAA.
- `rst` asserted low for one cycle mid-RUN:
  - All outputs go 0 immediately.
  - INIT restarts at address 0; previously written reg 4 reads 0 afterwards.
  - `ptr` is back to 0.
